data_mem_responder: RTL
=======================

# data_mem_responder

Data-memory responder for the 32-bit pipelined MIPS core: the memory-side end of the M-stage access interface. It accepts the M-stage store/load request (`memwriteM`, `resultsrcM`, `aluresultM`, `writedataM`) and returns `readdataW` registered, aligned with the W stage. Also provides a debug/preload port, access-error flags, saturating access counters and an optional post-reset clear sweep.

## Interface
- `DEPTH_WORDS`, 256: memory size in 32-bit words; power of two, 4..65536.
- `CLEAR_ON_RESET`, 0: 1 = zero the whole array after reset via the CLEAR sweep.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `memwriteM` in 1: store request this cycle.
- `resultsrcM` in 2: 2'b01 = load request; other values = no load.
- `aluresultM` in 32: byte address.
- `writedataM` in 32: store data.
- `readdataW` out 32: load data, valid the cycle after the request.
- `misalignW` out 1: previous-cycle access had `aluresultM[1:0]` != 0.
- `rangeerrW` out 1: previous-cycle access had address >= DEPTH_WORDS*4.
- `ready` out 1: 0 during the CLEAR sweep, 1 in RUN.
- `dbg_we` in 1: debug word write.
- `dbg_addr` in log2(DEPTH_WORDS): debug word index.
- `dbg_wdata` in 32: debug write data.
- `dbg_rdata` out 32: word at `dbg_addr`, registered one cycle.
- `store_cnt` out 16: accepted stores, saturating at 16'hFFFF.
- `load_cnt` out 16: accepted loads, saturating at 16'hFFFF.

## Operation
- Word index = `aluresultM[IDXW+1:2]`, IDXW = log2(DEPTH_WORDS).
- Request decode: store = `memwriteM`; load = `resultsrcM`==2'b01 and `!memwriteM`. If both are asserted, it is a store and `readdataW` is 0.
- Access check: misaligned (`aluresultM[1:0]`!=0) or out of range (`aluresultM[31:IDXW+2]`!=0) means the access is dropped (no write, load returns 0). The matching flag is asserted next cycle. Both flags may assert together. Counters do not increment on a dropped access.
- Accepted store writes the full word at the edge and increments `store_cnt`.
- Accepted load increments `load_cnt`.
- `readdataW` holds the loaded word on an accepted load, otherwise 0. It is never held from an earlier cycle.
- Debug write lands at the edge. If it hits the same index as an accepted pipeline store in the same cycle, the pipeline store wins.
- FSM states: CLEAR, RUN.
  - Reset: if `CLEAR_ON_RESET`=1, go to CLEAR with sweep pointer 0; else go to RUN. Array contents are untouched in that case.
  - CLEAR: write 0 to the pointer's word and increment the pointer each cycle. After writing DEPTH_WORDS-1, go to RUN.
  - Pipeline and debug accesses during CLEAR are dropped silently: no flags, no counters, `readdataW`=0.
  - `rst` asserted mid-sweep or mid-RUN restarts from the reset state. The sweep pointer returns to 0.

## Timing
- Reset values: `readdataW`=0, `misalignW`=0, `rangeerrW`=0, `dbg_rdata`=0, `store_cnt`=0, `load_cnt`=0. `ready`=0 if `CLEAR_ON_RESET` else 1, valid the cycle after `rst` is sampled high.
- Load latency is 1 cycle. Request in cycle N gives `readdataW`/flags in cycle N+1.
- Store in cycle N followed by a load of the same word in N+1 returns the new data.
- Debug write in N followed by debug read in N+1 returns the new data.
- Debug read and pipeline store to the same word in the same cycle N: `dbg_rdata` in N+1 shows the old data (read-before-write).
- CLEAR lasts exactly DEPTH_WORDS cycles. `ready` rises the cycle after the last sweep write.
- Counters update at the edge ending the request cycle and stick at 16'hFFFF.

## Test plan
- Store 32'hDEADBEEF to address 0x10, then load 0x10 the next cycle: `readdataW`=32'hDEADBEEF one cycle after the load, `store_cnt`=1, `load_cnt`=1.
- Store to 0x13, then load from 0x0F: the store is dropped (word 4 unchanged), `misalignW`=1 after each request, `readdataW`=0, counters unchanged.
- With DEPTH_WORDS=256, load from 0x400: `rangeerrW`=1 and `readdataW`=0. Load from 0x3FC: accepted, flags 0.
- `CLEAR_ON_RESET`=1, preload word 5 = 32'h1234 via debug, pulse `rst`: `ready`=0 for 256 cycles, then word 5 reads 0. Re-pulse `rst` at sweep cycle 100: sweep restarts and `ready` is low for a further 256 cycles.
- Same-cycle pipeline store of 32'hA to word 7 and debug write of 32'hB to word 7: word 7 = 32'hA.
- Issue 65540 accepted stores: `store_cnt` saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/data_mem_responder.sv
// Memory-side end of the MIPS M-stage access port, with debug port, error flags, counters and an optional clear sweep.
// Loads and debug reads take 1 cycle; there is no backpressure other than ready=0 while the clear sweep runs.
module data_mem_responder #(
  parameter int DEPTH_WORDS    = 256,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           memwriteM,
  input  logic [1:0]                     resultsrcM,
  input  logic [31:0]                    aluresultM,
  input  logic [31:0]                    writedataM,
  output logic [31:0]                    readdataW,
  output logic                           misalignW,
  output logic                           rangeerrW,
  output logic                           ready,
  input  logic                           dbg_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
  input  logic [31:0]                    dbg_wdata,
  output logic [31:0]                    dbg_rdata,
  output logic [15:0]                    store_cnt,
  output logic [15:0]                    load_cnt
);
  localparam int IDXW = $clog2(DEPTH_WORDS);

  typedef logic [IDXW-1:0] idx_t;

  typedef struct packed {
    logic store;
    logic load;
    logic misalign;
    logic rangeErr;
    idx_t idx;
  } req_t;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t      state;
  state_t      stateNext;
  idx_t        clrPtr;
  idx_t        clrPtrNext;
  logic        clrWe;
  req_t        req;
  logic        running;
  logic        access;
  logic        storeOk;
  logic        loadOk;
  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    req          = '0;
    req.store    = memwriteM;
    req.load     = (resultsrcM == 2'b01) && !memwriteM;
    req.misalign = |aluresultM[1:0];
    req.rangeErr = |aluresultM[31:IDXW+2];
    req.idx      = aluresultM[IDXW+1:2];
  end

  assign running = (state == RUN);
  assign access  = req.store || req.load;
  assign storeOk = running && req.store && !req.misalign && !req.rangeErr;
  assign loadOk  = running && req.load && !req.misalign && !req.rangeErr;
  assign ready   = running;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CLEAR_ON_RESET ? CLEAR : RUN;
      clrPtr <= '0;
    end else begin
      state  <= stateNext;
      clrPtr <= clrPtrNext;
    end
  end

  always_comb begin
    stateNext  = state;
    clrPtrNext = clrPtr;
    clrWe      = 1'b0;
    case (state)
      CLEAR: begin
        clrWe      = 1'b1;
        clrPtrNext = clrPtr + 1'b1;
        if (clrPtr == idx_t'(DEPTH_WORDS - 1)) stateNext = RUN;
      end
      RUN: begin
        stateNext = RUN;
      end
      default: stateNext = RUN;
    endcase
  end

  // Pipeline store is written after the debug write so it wins on a shared index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clrWe) begin
        mem[clrPtr] <= '0;
      end else begin
        if (dbg_we)  mem[dbg_addr] <= dbg_wdata;
        if (storeOk) mem[req.idx]  <= writedataM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      readdataW <= '0;
      misalignW <= 1'b0;
      rangeerrW <= 1'b0;
      dbg_rdata <= '0;
      store_cnt <= '0;
      load_cnt  <= '0;
    end else begin
      readdataW <= loadOk ? mem[req.idx] : '0;
      misalignW <= running && access && req.misalign;
      rangeerrW <= running && access && req.rangeErr;
      dbg_rdata <= running ? mem[dbg_addr] : '0;
      if (storeOk && (store_cnt != 16'hFFFF)) store_cnt <= store_cnt + 16'd1;
      if (loadOk && (load_cnt != 16'hFFFF))   load_cnt  <= load_cnt + 16'd1;
    end
  end
endmodule
